// File: rtl/btn_event_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : btn_event_scheduler
// Brief    : Four-button debouncer feeding a round-robin event arbiter with a
//            valid/ready event port. A free-running prescaler produces the
//            sample strobe. Long-press events are compiled in when the macro
//            BTN_LONG_PRESS_EN is defined. Without it, evt_long is tied low.
// Revision : 1.0 - initial release
// =============================================================================
module btn_event_scheduler #(
    parameter int DIV_W      = 19,
    parameter int LONG_TICKS = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] btn_raw,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic       evt_long,
    output logic [3:0] btn_level,
    output logic       tick
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Prescaler and debounce state
    logic [DIV_W-1:0] r_presc;
    logic             w_tick;
    // Two stored samples per button; together with the bit captured on the
    // current tick they form the three-sample debounce window.
    logic [1:0]       r_samp [4];
    logic [3:0]       r_level;
    logic [3:0]       w_all1;
    logic [3:0]       w_all0;
    logic [3:0]       w_rise;

    // Pending events and arbiter
    logic [3:0]       r_pend;
    logic [3:0]       w_cand;
    logic [3:0]       w_srv;
    logic [3:0]       w_srv_short;
    logic             w_hs;
    logic [1:0]       w_win;
    state_t           r_state;
    logic             r_evt_valid;
    logic [1:0]       r_evt_id;
    logic [1:0]       r_last_grant;

`ifdef BTN_LONG_PRESS_EN
    localparam int c_HOLD_W = $clog2(LONG_TICKS + 1);

    logic [c_HOLD_W-1:0] r_hold [4];
    logic [3:0]          r_lpend;
    logic [3:0]          w_lset;
    logic [3:0]          w_srv_long;
    logic                r_evt_long;
    logic                w_win_long;
`else
    // Keeps LONG_TICKS referenced when the long-press logic is compiled out.
    logic                w_unused_long_ticks;
    assign w_unused_long_ticks = ^LONG_TICKS;
`endif

    // Free-running prescaler; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    assign w_tick = &r_presc;

    // Window decode on the value the sample register takes this tick.
    always_comb begin
        w_all1 = '0;
        w_all0 = '0;
        for (int i = 0; i < 4; i++) begin
            w_all1[i] = ({r_samp[i], btn_raw[i]} == 3'b111);
            w_all0[i] = ({r_samp[i], btn_raw[i]} == 3'b000);
        end
    end

    // Sample raw buttons on each tick and apply set/clear hysteresis.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 4; i++) begin
                r_samp[i] <= '0;
            end
            r_level <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < 4; i++) begin
                r_samp[i] <= {r_samp[i][0], btn_raw[i]};
            end
            r_level <= (r_level | w_all1) & ~w_all0;
        end
    end

    // A press is the tick on which a low level sees three high samples.
    assign w_rise = {4{w_tick}} & w_all1 & ~r_level;

    // Handshake decode: one-hot of the button whose event is being accepted.
    assign w_hs  = r_evt_valid & evt_ready;
    assign w_srv = w_hs ? (4'b0001 << r_evt_id) : 4'b0000;

`ifdef BTN_LONG_PRESS_EN
    assign w_srv_short = r_evt_long ? 4'b0000 : w_srv;
    assign w_srv_long  = r_evt_long ? w_srv : 4'b0000;
    assign w_cand      = r_pend | r_lpend;
`else
    assign w_srv_short = w_srv;
    assign w_cand      = r_pend;
`endif

    // Short-press pending bits; a new press in the serve cycle wins.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_srv_short) | w_rise;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    // The long event fires on the tick that takes the hold count to LONG_TICKS.
    always_comb begin
        w_lset = '0;
        for (int i = 0; i < 4; i++) begin
            w_lset[i] = w_tick && r_level[i] &&
                        (r_hold[i] == c_HOLD_W'(LONG_TICKS - 1));
        end
    end

    // Saturating hold counters and long-press pending bits.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
            r_lpend <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!r_level[i]) begin
                    r_hold[i] <= '0;
                end else if (w_tick && (r_hold[i] != c_HOLD_W'(LONG_TICKS))) begin
                    r_hold[i] <= r_hold[i] + c_HOLD_W'(1);
                end
            end
            r_lpend <= (r_lpend & ~w_srv_long) | w_lset;
        end
    end
`endif

    // Round-robin pick: scanning downward lets the nearest index after
    // last_grant overwrite the farther ones; last_grant itself is last.
    always_comb begin
        w_win = r_last_grant;
        for (int k = 4; k >= 1; k--) begin
            if (w_cand[r_last_grant + 2'(k)]) begin
                w_win = r_last_grant + 2'(k);
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    // Short events go first when both kinds are pending for the winner.
    assign w_win_long = ~r_pend[w_win];
`endif

    // Arbiter FSM with registered event outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state      <= ST_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= 2'd0;
            r_last_grant <= 2'd3;
`ifdef BTN_LONG_PRESS_EN
            r_evt_long   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_state     <= ST_OFFER;
                        r_evt_valid <= 1'b1;
                        r_evt_id    <= w_win;
`ifdef BTN_LONG_PRESS_EN
                        r_evt_long  <= w_win_long;
`endif
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        r_state      <= ST_IDLE;
                        r_evt_valid  <= 1'b0;
                        r_last_grant <= r_evt_id;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
`ifdef BTN_LONG_PRESS_EN
    assign evt_long  = r_evt_long;
`else
    assign evt_long  = 1'b0;
`endif
    assign btn_level = r_level;
    assign tick      = w_tick;

endmodule
`default_nettype wire
